// File: rtl/sqrt_table_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_table_gen_pkg
// Description : Shared constants for the square-root table generator:
//               default table geometry, radicand width, entry count and
//               the FSM state encoding used by sqrt_table_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package sqrt_table_gen_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int RAD_WIDTH      = 2 * DEF_DATA_WIDTH;
    localparam int ENTRY_COUNT    = 1 << DEF_ADDR_WIDTH;

    localparam int         STATE_W = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sqrt_table_gen_isqrt_step.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_step
// Description : One combinational iteration of a restoring integer square
//               root. Brings down the next two radicand bits, tries to
//               subtract (4*root + 1) and produces one new root bit.
// Ports       : rem_in/root_in  - state before the iteration
//               rad_bits        - next two radicand bits, MSB pair first
//               rem_out/root_out- state after the iteration
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_step #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH+1:0] rem_in,
    input  logic [DATA_WIDTH-1:0] root_in,
    input  logic [1:0]            rad_bits,
    output logic [DATA_WIDTH+1:0] rem_out,
    output logic [DATA_WIDTH-1:0] root_out
);

    localparam int c_W = DATA_WIDTH + 4;

    logic [c_W-1:0] w_shifted;
    logic [c_W-1:0] w_trial;
    logic [c_W-1:0] w_diff;
    logic           w_fits;
    logic           w_unused_hi;

    assign w_shifted = {rem_in, rad_bits};
    assign w_trial   = {2'b00, root_in, 2'b01};
    assign w_fits    = (w_shifted >= w_trial);
    assign w_diff    = w_shifted - w_trial;

    // The remainder never exceeds 2*root, so it always fits DATA_WIDTH+2 bits
    // and the widened top bits (and the root MSB shifted out) are discarded.
    assign w_unused_hi = ^{w_diff[c_W-1:c_W-2], w_shifted[c_W-1:c_W-2], root_in[DATA_WIDTH-1]};

    assign rem_out  = w_fits ? w_diff[DATA_WIDTH+1:0] : w_shifted[DATA_WIDTH+1:0];
    assign root_out = {root_in[DATA_WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/sqrt_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_table_gen
// Description : Generates a table of floor(sqrt(a * 2^8)) for every address
//               a and streams it out through a ready/valid RAM write port.
//               Each entry takes DATA_WIDTH CALC cycles (one root bit per
//               cycle) followed by a WRITE that waits for wr_ready.
// Ports       : clk, rst (async, active-high)
//               start    - begin a full table run (only honoured in IDLE)
//               busy     - run in progress
//               done     - one-cycle pulse after the final entry is written
//               wr_en/wr_addr/wr_data/wr_ready - table RAM write handshake
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_table_gen
    import sqrt_table_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready
);

    localparam int c_RAD_W  = 2 * DATA_WIDTH;
    localparam int c_REM_W  = DATA_WIDTH + 2;
    localparam int c_ITER_W = $clog2(DATA_WIDTH);
    localparam logic [c_ITER_W-1:0]   c_ITER_LAST = c_ITER_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = '1;

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_RAD_W-1:0]    r_rad;
    logic [c_REM_W-1:0]    r_rem;
    logic [DATA_WIDTH-1:0] r_root;
    logic [c_ITER_W-1:0]   r_iter;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic [c_REM_W-1:0]    w_rem_next;
    logic [DATA_WIDTH-1:0] w_root_next;
    logic                  w_calc_last;
    logic                  w_accept;
    logic                  w_addr_last;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [c_RAD_W-1:0]    w_rad_load;

    isqrt_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_in   (r_rem),
        .root_in  (r_root),
        .rad_bits (r_rad[c_RAD_W-1 -: 2]),
        .rem_out  (w_rem_next),
        .root_out (w_root_next)
    );

    assign w_calc_last = (r_state == S_CALC) && (r_iter == c_ITER_LAST);
    assign w_accept    = (r_state == S_WRITE) && wr_ready;
    assign w_addr_last = (r_addr == c_ADDR_LAST);
    assign w_addr_inc  = r_addr + 1'b1;
    // Radicand is the address scaled by 2^8 so the root carries 4 fraction bits.
    assign w_rad_load  = {w_addr_inc, {(c_RAD_W - ADDR_WIDTH){1'b0}}};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_state_next = S_CALC;
            S_CALC:  if (w_calc_last) w_state_next = S_WRITE;
            S_WRITE: if (w_accept)    w_state_next = w_addr_last ? S_FIN : S_CALC;
            S_FIN:                    w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        wr_en = 1'b0;
        case (r_state)
            S_CALC:  busy = 1'b1;
            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            S_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_iter    <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Address 0 has an all-zero radicand.
                        r_addr <= '0;
                        r_rad  <= '0;
                        r_rem  <= '0;
                        r_root <= '0;
                        r_iter <= '0;
                    end
                end
                S_CALC: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_iter <= r_iter + 1'b1;
                    if (w_calc_last) begin
                        r_wr_data <= w_root_next;
                    end
                end
                S_WRITE: begin
                    // The last address terminates the run instead of wrapping.
                    if (wr_ready && !w_addr_last) begin
                        r_addr <= w_addr_inc;
                        r_rad  <= w_rad_load;
                        r_rem  <= '0;
                        r_root <= '0;
                        r_iter <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_addr = r_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire
